// File: rtl/cmd_status_handshake.sv
// cmd_status_handshake: turns the HPS command PIO request level into a single
// engine start pulse, tracks the engine to completion, and presents a
// four-phase done flag to the status PIO (req up, done up, req down, done down).
// Optional feature macro: CMD_STATUS_TIMEOUT_EN adds the WAIT-state watchdog
// and the status_err flag; without it WAIT exits only on eng_done.
module cmd_status_handshake #(
   parameter int TIMEOUT_CYCLES = 1000000,
   parameter int CNT_W          = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_req,
   output logic             eng_start,
   input  logic             eng_done,
   output logic             status_done,
   output logic             status_err,
   output logic [CNT_W-1:0] cmd_count
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t state;
   state_t state_nx;
   logic   req_q;
   logic   req_edge;
   logic   enter_done;
   logic   tmo_hit;

   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("cmd_status_handshake: TIMEOUT_CYCLES must be >= 2");
   end

   // req_q resets high so a request already asserted across reset is not taken
   assign req_edge = cmd_req & ~req_q;

   // Request level history for edge detection
   always_ff @(posedge clk) begin
      if (reset) req_q <= 1'b1;
      else       req_q <= cmd_req;
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   // Next-state decode; enter_done marks every transition into DONE
   always_comb begin
      state_nx   = state;
      enter_done = 1'b0;
      case (state)
         IDLE: begin
            if (req_edge) state_nx = START;
         end
         START: begin
            if (eng_done) begin
               state_nx   = DONE;
               enter_done = 1'b1;
            end else begin
               state_nx   = WAIT;
            end
         end
         WAIT: begin
            if (eng_done || tmo_hit) begin
               state_nx   = DONE;
               enter_done = 1'b1;
            end
         end
         DONE: begin
            if (!cmd_req) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Completed-command counter, wraps naturally at 2^CNT_W
   always_ff @(posedge clk) begin
      if (reset)           cmd_count <= '0;
      else if (enter_done) cmd_count <= cmd_count + 1'b1;
   end

   // Outputs decode straight from the state register, so reset cuts eng_start
   assign eng_start   = (state == START);
   assign status_done = (state == DONE);

`ifdef CMD_STATUS_TIMEOUT_EN
   localparam int              TMO_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   logic [TMO_W-1:0] tmo_cnt;
   logic             err_q;

   // Timeout fires on the WAIT cycle whose count reaches the last value;
   // eng_done in the same cycle wins because it is tested first above
   assign tmo_hit = (state == WAIT) && (tmo_cnt == TMO_LAST);

   // Watchdog: cleared in START, counts each WAIT cycle
   always_ff @(posedge clk) begin
      if (reset)                          tmo_cnt <= '0;
      else if (state == START)            tmo_cnt <= '0;
      else if (state == WAIT && !tmo_hit) tmo_cnt <= tmo_cnt + 1'b1;
   end

   // Exit cause latched on DONE entry, cleared together with status_done
   always_ff @(posedge clk) begin
      if (reset)                           err_q <= 1'b0;
      else if (enter_done)                 err_q <= (state == WAIT) && !eng_done;
      else if (state == DONE && !cmd_req)  err_q <= 1'b0;
   end

   assign status_err = err_q;
`else
   assign tmo_hit    = 1'b0;
   assign status_err = 1'b0;
`endif

endmodule

// File: tb/tb_cmd_status_handshake.sv
// Scoreboard bench for cmd_status_handshake: each command pushes its expected
// completion (err flag, count) when the request is driven and pops it when
// status_done is observed.
module tb_cmd_status_handshake;

   localparam int TMO = 16;

   typedef struct packed {
      logic       err;
      logic [7:0] cnt;
   } exp_t;

   logic       clk;
   logic       reset;
   logic       cmd_req;
   logic       eng_start;
   logic       eng_done;
   logic       status_done;
   logic       status_err;
   logic [7:0] cmd_count;

   int         errors = 0;
   int         checks = 0;
   int         start_pulses = 0;
   logic [7:0] exp_count = 8'd0;
   exp_t       sb[$];

   cmd_status_handshake #(
      .TIMEOUT_CYCLES(TMO),
      .CNT_W(8)
   ) dut (
      .clk(clk),
      .reset(reset),
      .cmd_req(cmd_req),
      .eng_start(eng_start),
      .eng_done(eng_done),
      .status_done(status_done),
      .status_err(status_err),
      .cmd_count(cmd_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // eng_start is high for a whole cycle, so each pulse spans one negedge
   always @(negedge clk) if (eng_start === 1'b1) start_pulses++;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got hang want finish");
      $fatal(1, "bench watchdog expired");
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Drive one command: eng_done arrives 'delay' cycles after eng_start (0 = same cycle)
   task automatic run_cmd(input int delay, input string name);
      int   p0;
      exp_t e;
      p0 = start_pulses;
      cmd_req = 1'b1;
      cyc();
      checks++;
      if (eng_start !== 1'b1) begin
         errors++;
         $display("FAIL %s.start: eng_start=%b want 1", name, eng_start);
      end
      exp_count = exp_count + 8'd1;
      sb.push_back('{err: 1'b0, cnt: exp_count});
      if (delay > 0) repeat (delay) cyc();
      eng_done = 1'b1;
      cyc();
      eng_done = 1'b0;
      e = sb.pop_front();
      checks++;
      if (status_done !== 1'b1) begin
         errors++;
         $display("FAIL %s.done: status_done=%b want 1", name, status_done);
      end
      checks++;
      if (status_err !== e.err) begin
         errors++;
         $display("FAIL %s.err: status_err=%b want %b", name, status_err, e.err);
      end
      checks++;
      if (cmd_count !== e.cnt) begin
         errors++;
         $display("FAIL %s.count: cmd_count=%0d want %0d", name, cmd_count, e.cnt);
      end
      cyc();
      checks++;
      if (status_done !== 1'b1) begin
         errors++;
         $display("FAIL %s.hold: status_done=%b want 1", name, status_done);
      end
      cmd_req = 1'b0;
      cyc();
      checks++;
      if (status_done !== 1'b0 || status_err !== 1'b0) begin
         errors++;
         $display("FAIL %s.release: done=%b err=%b want 0 0", name, status_done, status_err);
      end
      checks++;
      if (start_pulses !== p0 + 1) begin
         errors++;
         $display("FAIL %s.pulses: eng_start pulses=%0d want %0d", name, start_pulses - p0, 1);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      cmd_req = 1'b0;
      eng_done = 1'b0;
      repeat (3) cyc();
      reset = 1'b0;
      cyc();
      checks++;
      if (eng_start !== 1'b0) begin errors++; $display("FAIL reset.start: got %b want 0", eng_start); end
      checks++;
      if (status_done !== 1'b0) begin errors++; $display("FAIL reset.done: got %b want 0", status_done); end
      checks++;
      if (status_err !== 1'b0) begin errors++; $display("FAIL reset.err: got %b want 0", status_err); end
      checks++;
      if (cmd_count !== 8'd0) begin errors++; $display("FAIL reset.count: got %0d want 0", cmd_count); end
      exp_count = 8'd0;
   endtask

   task automatic test_nominal();
      run_cmd(5, "nominal");
   endtask

   task automatic test_fast_engine();
      run_cmd(0, "fast");
   endtask

   task automatic test_back_to_back();
      run_cmd(1, "b2b_a");
      run_cmd(3, "b2b_b");
      run_cmd(0, "b2b_c");
   endtask

   task automatic test_idle_done_ignored();
      int p0;
      p0 = start_pulses;
      eng_done = 1'b1;
      cyc();
      eng_done = 1'b0;
      cyc();
      checks++;
      if (status_done !== 1'b0 || cmd_count !== exp_count) begin
         errors++;
         $display("FAIL idle_done: done=%b count=%0d want 0 %0d", status_done, cmd_count, exp_count);
      end
      checks++;
      if (start_pulses !== p0) begin
         errors++;
         $display("FAIL idle_done.pulses: got %0d want 0", start_pulses - p0);
      end
   endtask

   task automatic test_timeout();
      int   p0;
      exp_t e;
      p0 = start_pulses;
      cmd_req = 1'b1;
      cyc();
      checks++;
      if (eng_start !== 1'b1) begin errors++; $display("FAIL tmo.start: got %b want 1", eng_start); end
`ifdef CMD_STATUS_TIMEOUT_EN
      exp_count = exp_count + 8'd1;
      sb.push_back('{err: 1'b1, cnt: exp_count});
      cyc();
      repeat (TMO - 1) cyc();
      checks++;
      if (status_done !== 1'b0) begin errors++; $display("FAIL tmo.early: status_done=%b want 0", status_done); end
      cyc();
      e = sb.pop_front();
      checks++;
      if (status_done !== 1'b1) begin errors++; $display("FAIL tmo.done: status_done=%b want 1", status_done); end
      checks++;
      if (status_err !== e.err) begin errors++; $display("FAIL tmo.err: status_err=%b want %b", status_err, e.err); end
      checks++;
      if (cmd_count !== e.cnt) begin errors++; $display("FAIL tmo.count: got %0d want %0d", cmd_count, e.cnt); end
      eng_done = 1'b1;
      cyc();
      eng_done = 1'b0;
      cyc();
      checks++;
      if (status_done !== 1'b1 || status_err !== 1'b1 || cmd_count !== exp_count) begin
         errors++;
         $display("FAIL tmo.late_done: done=%b err=%b count=%0d want 1 1 %0d",
                  status_done, status_err, cmd_count, exp_count);
      end
`else
      repeat (100) cyc();
      checks++;
      if (status_done !== 1'b0 || status_err !== 1'b0) begin
         errors++;
         $display("FAIL notmo.wait: done=%b err=%b want 0 0", status_done, status_err);
      end
      checks++;
      if (cmd_count !== exp_count) begin errors++; $display("FAIL notmo.count: got %0d want %0d", cmd_count, exp_count); end
      exp_count = exp_count + 8'd1;
      sb.push_back('{err: 1'b0, cnt: exp_count});
      eng_done = 1'b1;
      cyc();
      eng_done = 1'b0;
      e = sb.pop_front();
      checks++;
      if (status_done !== 1'b1 || status_err !== e.err) begin
         errors++;
         $display("FAIL notmo.done: done=%b err=%b want 1 %b", status_done, status_err, e.err);
      end
      checks++;
      if (cmd_count !== e.cnt) begin errors++; $display("FAIL notmo.count2: got %0d want %0d", cmd_count, e.cnt); end
`endif
      cmd_req = 1'b0;
      cyc();
      checks++;
      if (status_done !== 1'b0 || status_err !== 1'b0) begin
         errors++;
         $display("FAIL tmo.release: done=%b err=%b want 0 0", status_done, status_err);
      end
      checks++;
      if (start_pulses !== p0 + 1) begin errors++; $display("FAIL tmo.pulses: got %0d want 1", start_pulses - p0); end
   endtask

   task automatic test_early_release();
      int   p0;
      exp_t e;
      p0 = start_pulses;
      cmd_req = 1'b1;
      cyc();
      exp_count = exp_count + 8'd1;
      sb.push_back('{err: 1'b0, cnt: exp_count});
      cyc();
      cyc();
      cmd_req = 1'b0;
      cyc();
      cmd_req = 1'b1;
      cyc();
      cmd_req = 1'b0;
      cyc();
      eng_done = 1'b1;
      cyc();
      eng_done = 1'b0;
      e = sb.pop_front();
      checks++;
      if (status_done !== 1'b1 || cmd_count !== e.cnt) begin
         errors++;
         $display("FAIL early.done: done=%b count=%0d want 1 %0d", status_done, cmd_count, e.cnt);
      end
      cyc();
      checks++;
      if (status_done !== 1'b0) begin errors++; $display("FAIL early.one_cycle: status_done=%b want 0", status_done); end
      repeat (3) cyc();
      checks++;
      if (start_pulses !== p0 + 1) begin errors++; $display("FAIL early.pulses: got %0d want 1", start_pulses - p0); end
   endtask

   task automatic test_reset_behaviour();
      int p0;
      cmd_req = 1'b1;
      reset = 1'b1;
      repeat (2) cyc();
      reset = 1'b0;
      p0 = start_pulses;
      repeat (5) cyc();
      checks++;
      if (start_pulses !== p0 || eng_start !== 1'b0) begin
         errors++;
         $display("FAIL rst_held.start: pulses=%0d eng_start=%b want 0 0", start_pulses - p0, eng_start);
      end
      exp_count = 8'd0;
      cmd_req = 1'b0;
      cyc();
      cmd_req = 1'b1;
      cyc();
      cyc();
      cyc();
      reset = 1'b1;
      cyc();
      checks++;
      if (eng_start !== 1'b0 || status_done !== 1'b0 || status_err !== 1'b0 || cmd_count !== 8'd0) begin
         errors++;
         $display("FAIL rst_wait.outputs: start=%b done=%b err=%b count=%0d want 0 0 0 0",
                  eng_start, status_done, status_err, cmd_count);
      end
      reset = 1'b0;
      cmd_req = 1'b0;
      cyc();
      exp_count = 8'd0;
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 256; i++) run_cmd(0, "wrap");
      checks++;
      if (cmd_count !== 8'd0) begin errors++; $display("FAIL wrap.count: got %0d want 0", cmd_count); end
   endtask

   initial begin
      reset = 1'b1;
      cmd_req = 1'b0;
      eng_done = 1'b0;
      test_reset();
      test_nominal();
      test_fast_engine();
      test_back_to_back();
      test_idle_done_ignored();
      test_timeout();
      test_early_release();
      test_reset_behaviour();
      test_wrap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
